// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_BREAK  = 3'd6
  } uart_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchronizer, bit-period counter and 3-sample majority vote.
// The counter runs only while the frame FSM is inside a frame, so it is
// 0 on every state entry; it also wraps at the end of each bit period.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 32'd10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic i_run,
  output logic o_din_sync,
  output logic o_fall,
  output logic o_bit_valid,
  output logic o_bit_value,
  output logic o_bit_end
);

  localparam int unsigned MID = CLOCKS_PER_BIT / 2;
  localparam int unsigned CW  = $clog2(CLOCKS_PER_BIT + 1);
  localparam logic [CW-1:0] C_MID_M1 = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID    = CW'(MID);
  localparam logic [CW-1:0] C_MID_P1 = CW'(MID + 1);
  localparam logic [CW-1:0] C_LAST   = CW'(CLOCKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_flush;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_s0;
  logic          r_s1;

  // Two-flop synchronizer on the asynchronous serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Falling-edge detector; ignores the synchronizer's reset value so a line
  // already low at reset release is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush <= 2'd0;
      r_prev  <= 1'b0;
    end else begin
      if (r_flush != 2'd2) r_flush <= r_flush + 2'd1;
      r_prev <= (r_flush == 2'd2) ? r_sync2 : 1'b0;
    end
  end

  // Bit-period counter, held at 0 outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || (r_cnt == C_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (i_run) begin
      if (r_cnt == C_MID_M1) r_s0 <= r_sync2;
      if (r_cnt == C_MID)    r_s1 <= r_sync2;
    end
  end

  assign o_din_sync  = r_sync2;
  assign o_fall      = (r_flush == 2'd2) && r_prev && !r_sync2;
  assign o_bit_valid = i_run && (r_cnt == C_MID_P1);
  assign o_bit_value = maj3(r_s0, r_s1, r_sync2);
  assign o_bit_end   = i_run && (r_cnt == C_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive frame controller: start/data/parity/stop sequencing,
// write strobe and error/break event pulses.
//
//  state  | meaning
//  IDLE   | line idle, waiting for a falling edge
//  START  | validating the start bit (glitch reject)
//  DATA   | shifting in data bits, LSB first
//  PARITY | checking the parity bit
//  STOP   | checking stop bit(s); leaves at the last stop decision
//  WRITE  | one-cycle write strobe to the downstream FIFO
//  BREAK  | line held low; wait for it to return high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
  parameter int unsigned BAUD_RATE       = 32'd230400,
  parameter int unsigned WORD_WIDTH      = 32'd8,
  parameter logic [1:0]  PARITY_MODE     = 2'd0,
  parameter int unsigned STOP_BITS       = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  full,
  output logic                  we,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  break_det
);

  localparam int unsigned CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned IW = $clog2(WORD_WIDTH + 1);
  localparam logic [IW-1:0] C_WORD = IW'(WORD_WIDTH);

  uart_state_t           r_state;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_bit_idx;
  logic                  r_par_err;
  logic                  r_par_bit;
  logic                  r_stop_idx;
  logic [WORD_WIDTH-1:0] r_dout;
  logic                  r_we;
  logic                  r_perr;
  logic                  r_ferr;
  logic                  r_oerr;
  logic                  r_brk;

  logic w_run;
  logic w_din_sync;
  logic w_fall;
  logic w_bit_valid;
  logic w_bit_value;
  logic w_bit_end;
  logic w_par_exp;
  logic w_break_cand;

  assign w_run = (r_state == ST_START) || (r_state == ST_DATA) ||
                 (r_state == ST_PARITY) || (r_state == ST_STOP);

  uart_bit_sampler #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .i_run      (w_run),
    .o_din_sync (w_din_sync),
    .o_fall     (w_fall),
    .o_bit_valid(w_bit_valid),
    .o_bit_value(w_bit_value),
    .o_bit_end  (w_bit_end)
  );

  assign w_par_exp    = (PARITY_MODE == PARITY_ODD) ? ~(^r_shift) : (^r_shift);
  // A break is an all-zero frame: data, parity (when present) and stop.
  assign w_break_cand = (r_shift == '0) && ((PARITY_MODE == PARITY_NONE) || !r_par_bit);

  // Frame state machine with registered strobes and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '1;
      r_bit_idx  <= '0;
      r_par_err  <= 1'b0;
      r_par_bit  <= 1'b1;
      r_stop_idx <= 1'b0;
      r_dout     <= '0;
      r_we       <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_oerr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
      r_brk  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_bit_idx  <= '0;
            r_par_err  <= 1'b0;
            r_par_bit  <= 1'b1;
            r_stop_idx <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_valid && w_bit_value) begin
            r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (w_bit_valid) begin
            r_shift   <= {w_bit_value, r_shift[WORD_WIDTH-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end
          if (w_bit_end && (r_bit_idx == C_WORD)) begin
            r_stop_idx <= 1'b0;
            r_state    <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_bit_valid) begin
            r_par_bit <= w_bit_value;
            r_par_err <= w_bit_value ^ w_par_exp;
          end
          if (w_bit_end) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_bit_valid) begin
            if (!w_bit_value) begin
              if (!r_stop_idx && w_break_cand) begin
                r_brk   <= 1'b1;
                r_state <= ST_BREAK;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end else if ((STOP_BITS == 32'd2) && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
            end else if (full) begin
              r_oerr  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_we    <= 1'b1;
              r_dout  <= r_shift;
              r_perr  <= r_par_err;
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
        end
        ST_BREAK: begin
          if (w_din_sync) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout        = r_dout;
  assign we          = r_we;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;
  assign break_det   = r_brk;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1, 8E1 and 8N2 instances on one line.
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b1;
  logic full = 1'b0;

  logic [7:0] n1_dout, e1_dout, n2_dout;
  logic n1_we, n1_pe, n1_fe, n1_oe, n1_bk;
  logic e1_we, e1_pe, e1_fe, e1_oe, e1_bk;
  logic n2_we, n2_pe, n2_fe, n2_oe, n2_bk;

  int total = 0;
  int bad = 0;

  int n1_we_c, n1_fe_c, n1_oe_c, n1_bk_c;
  int e1_we_c, e1_fe_c, e1_bk_c;
  int n2_we_c, n2_fe_c, n2_bk_c;
  int excl_bad = 0;
  logic [7:0] n1_dout_cap, e1_dout_cap;
  logic e1_pe_cap;

  always #5 clk = ~clk;

  uart_rx_core #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
                 .WORD_WIDTH(32'd8), .PARITY_MODE(2'd0), .STOP_BITS(32'd1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(n1_dout), .full(full), .we(n1_we),
    .parity_err(n1_pe), .frame_err(n1_fe), .overrun_err(n1_oe), .break_det(n1_bk));

  uart_rx_core #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
                 .WORD_WIDTH(32'd8), .PARITY_MODE(2'd1), .STOP_BITS(32'd1)) u_e1 (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(e1_dout), .full(full), .we(e1_we),
    .parity_err(e1_pe), .frame_err(e1_fe), .overrun_err(e1_oe), .break_det(e1_bk));

  uart_rx_core #(.CLOCK_FREQUENCY(32'd1_000_000), .BAUD_RATE(32'd100_000),
                 .WORD_WIDTH(32'd8), .PARITY_MODE(2'd0), .STOP_BITS(32'd2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(n2_dout), .full(full), .we(n2_we),
    .parity_err(n2_pe), .frame_err(n2_fe), .overrun_err(n2_oe), .break_det(n2_bk));

  // Pulse counters and captures, sampled mid-cycle.
  always @(negedge clk) begin
    if (n1_we) begin n1_we_c = n1_we_c + 1; n1_dout_cap = n1_dout; end
    if (n1_fe) n1_fe_c = n1_fe_c + 1;
    if (n1_oe) n1_oe_c = n1_oe_c + 1;
    if (n1_bk) n1_bk_c = n1_bk_c + 1;
    if (e1_we) begin e1_we_c = e1_we_c + 1; e1_dout_cap = e1_dout; e1_pe_cap = e1_pe; end
    if (e1_fe) e1_fe_c = e1_fe_c + 1;
    if (e1_bk) e1_bk_c = e1_bk_c + 1;
    if (n2_we) n2_we_c = n2_we_c + 1;
    if (n2_fe) n2_fe_c = n2_fe_c + 1;
    if (n2_bk) n2_bk_c = n2_bk_c + 1;
    if ((int'(n1_we) + int'(n1_fe) + int'(n1_oe) + int'(n1_bk)) > 1) excl_bad = excl_bad + 1;
  end

  task automatic clear_counts();
    n1_we_c = 0; n1_fe_c = 0; n1_oe_c = 0; n1_bk_c = 0;
    e1_we_c = 0; e1_fe_c = 0; e1_bk_c = 0;
    n2_we_c = 0; n2_fe_c = 0; n2_bk_c = 0;
    n1_dout_cap = 8'h00; e1_dout_cap = 8'h00; e1_pe_cap = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    din = b;
    wait_cycles(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par_bit,
                            input int nstop, input logic stop1, input logic stop2);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(par_bit);
    send_bit(stop1);
    if (nstop == 2) send_bit(stop2);
    din = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    total++; if (n1_dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", n1_dout); end
    total++; if (n1_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", n1_we); end
    total++; if (n1_pe !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%b exp=0", n1_pe); end
    total++; if (n1_fe !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", n1_fe); end
    total++; if (n1_oe !== 1'b0) begin bad++; $display("FAIL reset_overrun_err got=%b exp=0", n1_oe); end
    total++; if (n1_bk !== 1'b0) begin bad++; $display("FAIL reset_break_det got=%b exp=0", n1_bk); end
    rst_n = 1'b1;
    wait_cycles(10);
  endtask

  task automatic test_8n1_a5();
    wait_cycles(120);
    clear_counts();
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(30);
    total++; if (n1_we_c !== 1) begin bad++; $display("FAIL a5_we_count got=%0d exp=1", n1_we_c); end
    total++; if (n1_dout_cap !== 8'hA5) begin bad++; $display("FAIL a5_dout got=%h exp=a5", n1_dout_cap); end
    total++; if (n1_fe_c !== 0) begin bad++; $display("FAIL a5_frame_err got=%0d exp=0", n1_fe_c); end
    total++; if (n1_oe_c !== 0) begin bad++; $display("FAIL a5_overrun got=%0d exp=0", n1_oe_c); end
    total++; if (n1_bk_c !== 0) begin bad++; $display("FAIL a5_break got=%0d exp=0", n1_bk_c); end
  endtask

  task automatic test_overrun();
    wait_cycles(120);
    clear_counts();
    full = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(30);
    total++; if (n1_we_c !== 0) begin bad++; $display("FAIL ovr_we_count got=%0d exp=0", n1_we_c); end
    total++; if (n1_oe_c !== 1) begin bad++; $display("FAIL ovr_overrun got=%0d exp=1", n1_oe_c); end
    total++; if (n1_dout !== 8'hA5) begin bad++; $display("FAIL ovr_dout_hold got=%h exp=a5", n1_dout); end
    full = 1'b0;
    wait_cycles(20);
    send_frame(8'h55, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(30);
    total++; if (n1_we_c !== 1) begin bad++; $display("FAIL ovr_next_we got=%0d exp=1", n1_we_c); end
    total++; if (n1_dout_cap !== 8'h55) begin bad++; $display("FAIL ovr_next_dout got=%h exp=55", n1_dout_cap); end
    total++; if (n1_oe_c !== 1) begin bad++; $display("FAIL ovr_next_overrun got=%0d exp=1", n1_oe_c); end
  endtask

  task automatic test_parity();
    wait_cycles(120);
    clear_counts();
    // 0x07 has three ones: even parity bit should be 1; send 0.
    send_frame(8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(30);
    total++; if (e1_we_c !== 1) begin bad++; $display("FAIL par_bad_we got=%0d exp=1", e1_we_c); end
    total++; if (e1_dout_cap !== 8'h07) begin bad++; $display("FAIL par_bad_dout got=%h exp=07", e1_dout_cap); end
    total++; if (e1_pe_cap !== 1'b1) begin bad++; $display("FAIL par_bad_flag got=%b exp=1", e1_pe_cap); end
    wait_cycles(120);
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    wait_cycles(30);
    total++; if (e1_we_c !== 1) begin bad++; $display("FAIL par_ok_we got=%0d exp=1", e1_we_c); end
    total++; if (e1_pe_cap !== 1'b0) begin bad++; $display("FAIL par_ok_flag got=%b exp=0", e1_pe_cap); end
    total++; if (e1_fe_c !== 0) begin bad++; $display("FAIL par_ok_frame_err got=%0d exp=0", e1_fe_c); end
  endtask

  task automatic test_two_stop();
    wait_cycles(120);
    clear_counts();
    send_frame(8'hFF, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    wait_cycles(30);
    total++; if (n2_fe_c !== 1) begin bad++; $display("FAIL stop2_frame_err got=%0d exp=1", n2_fe_c); end
    total++; if (n2_we_c !== 0) begin bad++; $display("FAIL stop2_we got=%0d exp=0", n2_we_c); end
    total++; if (n2_bk_c !== 0) begin bad++; $display("FAIL stop2_break got=%0d exp=0", n2_bk_c); end
  endtask

  task automatic test_glitch_break();
    wait_cycles(120);
    clear_counts();
    din = 1'b0;
    wait_cycles(3);
    din = 1'b1;
    wait_cycles(150);
    total++; if (n1_we_c !== 0) begin bad++; $display("FAIL glitch_we got=%0d exp=0", n1_we_c); end
    total++; if (n1_fe_c !== 0) begin bad++; $display("FAIL glitch_frame_err got=%0d exp=0", n1_fe_c); end
    total++; if (n1_oe_c !== 0) begin bad++; $display("FAIL glitch_overrun got=%0d exp=0", n1_oe_c); end
    total++; if (n1_bk_c !== 0) begin bad++; $display("FAIL glitch_break got=%0d exp=0", n1_bk_c); end
    din = 1'b0;
    wait_cycles(250);
    total++; if (n1_bk_c !== 1) begin bad++; $display("FAIL brk_count got=%0d exp=1", n1_bk_c); end
    total++; if (n1_fe_c !== 0) begin bad++; $display("FAIL brk_frame_err got=%0d exp=0", n1_fe_c); end
    total++; if (n1_we_c !== 0) begin bad++; $display("FAIL brk_we got=%0d exp=0", n1_we_c); end
    total++; if (e1_bk_c !== 1) begin bad++; $display("FAIL brk_e1_count got=%0d exp=1", e1_bk_c); end
    total++; if (n2_bk_c !== 1) begin bad++; $display("FAIL brk_n2_count got=%0d exp=1", n2_bk_c); end
    din = 1'b1;
    wait_cycles(150);
    total++; if (n1_bk_c !== 1) begin bad++; $display("FAIL brk_after_high got=%0d exp=1", n1_bk_c); end
    total++; if ((n1_we_c + n1_fe_c + n1_oe_c) !== 0) begin bad++;
      $display("FAIL brk_after_high_other got=%0d exp=0", n1_we_c + n1_fe_c + n1_oe_c); end
  endtask

  task automatic test_reset_midframe();
    wait_cycles(120);
    clear_counts();
    // 0x81 LSB first: 1,0,0,0,0,0,0,1; reset lands inside bit 4 (a 0).
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    din = 1'b0;
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    total++; if (n1_dout !== 8'h00) begin bad++; $display("FAIL mid_rst_dout got=%h exp=00", n1_dout); end
    total++; if (n1_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%b exp=0", n1_we); end
    total++; if ((n1_pe | n1_fe | n1_oe | n1_bk) !== 1'b0) begin bad++;
      $display("FAIL mid_rst_errs got=%b%b%b%b exp=0000", n1_pe, n1_fe, n1_oe, n1_bk); end
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    din = 1'b1;
    wait_cycles(120);
    total++; if (n1_we_c !== 0) begin bad++; $display("FAIL mid_no_we got=%0d exp=0", n1_we_c); end
    total++; if (n1_fe_c !== 0) begin bad++; $display("FAIL mid_no_frame_err got=%0d exp=0", n1_fe_c); end
    total++; if ((n1_oe_c + n1_bk_c) !== 0) begin bad++;
      $display("FAIL mid_no_other got=%0d exp=0", n1_oe_c + n1_bk_c); end
    clear_counts();
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    wait_cycles(30);
    total++; if (n1_we_c !== 1) begin bad++; $display("FAIL mid_next_we got=%0d exp=1", n1_we_c); end
    total++; if (n1_dout_cap !== 8'h81) begin bad++; $display("FAIL mid_next_dout got=%h exp=81", n1_dout_cap); end
  endtask

  initial begin
    clear_counts();
    @(posedge clk);
    #1;
    test_reset();
    test_8n1_a5();
    test_overrun();
    test_parity();
    test_two_stop();
    test_glitch_break();
    test_reset_midframe();
    total++; if (excl_bad !== 0) begin bad++; $display("FAIL pulse_exclusive got=%0d exp=0", excl_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
